subterranean_din_packer: RTL

- Transmit-side front end for the 4-round Subterranean duplex datapath.
- Accepts a stream of 32-bit words, each carrying a byte count of 0..4, and packs up to four of them into one 128-bit block.
- Produces, for the rounds core, the matching din_size[11:0] code (3 bits per word), enable_round (number of words minus one) and a valid/ready handshake.
- Double-buffered (accumulator plus output register), so the upstream can keep filling the next block while the core consumes the current one.

---
 rtl/subterranean_din_packer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/subterranean_din_packer.sv
// Packs a stream of 32-bit words (0..4 bytes each) into 128-bit duplex blocks
// for the Subterranean rounds core, with an accumulator plus an output register.
module subterranean_din_packer #(
    parameter bit MASK_UNUSED_BYTES = 1'b1
) (
    input  logic         clk,
    input  logic         arstn,
    input  logic         init,
    input  logic [31:0]  s_word,
    input  logic [2:0]   s_size,
    input  logic         s_last,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [127:0] m_din,
    output logic [11:0]  m_din_size,
    output logic [1:0]   m_enable_round,
    output logic         m_din_valid,
    input  logic         m_din_ready,
    output logic         busy
);

    typedef logic [1:0] slot_t;

    // Accumulator stage
    logic [31:0] acc_data [4];
    logic [2:0]  acc_size [4];
    slot_t       count;
    logic        complete;
    slot_t       pend_last;

    // Combinational view of the incoming word and the block being assembled
    logic [2:0]   size_c;
    logic [31:0]  word_m;
    logic         in_fire;
    logic         out_free;
    logic         blk_done;
    logic         load_out;
    slot_t        blk_last;
    logic [127:0] blk_data;
    logic [11:0]  blk_size;

    // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
    always_comb begin
        size_c = (s_size > 3'd4) ? 3'd4 : s_size;
        word_m = s_word;
        if (MASK_UNUSED_BYTES) begin
            for (int b = 0; b < 4; b++) begin
                if (3'(b) >= size_c) begin
                    word_m[8*b +: 8] = 8'h00;
                end
            end
        end
    end

    assign s_ready  = !complete;
    assign in_fire  = s_valid && s_ready;
    assign out_free = !m_din_valid || m_din_ready;

    // A partial word always closes the phase, as does the last slot or s_last.
    assign blk_done = in_fire && ((count == 2'd3) || s_last || (size_c < 3'd4));
    assign load_out = (complete || blk_done) && out_free;

    // The completing word is merged straight into the outgoing block so a
    // finished block reaches the output register one cycle after its last word.
    always_comb begin
        blk_last = complete ? pend_last : count;
        blk_data = '0;
        blk_size = '0;
        for (int k = 0; k < 4; k++) begin
            if (2'(k) <= blk_last) begin
                if (in_fire && (2'(k) == count)) begin
                    blk_data[32*k +: 32] = word_m;
                    blk_size[3*k +: 3]   = size_c;
                end else begin
                    blk_data[32*k +: 32] = acc_data[k];
                    blk_size[3*k +: 3]   = acc_size[k];
                end
            end
        end
    end

    // NOTE: the accumulator array is small, so it is reset along with the control state;
    // stale slots above blk_last are masked anyway, which is why init leaves them alone.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            count     <= '0;
            complete  <= 1'b0;
            pend_last <= '0;
            for (int k = 0; k < 4; k++) begin
                acc_data[k] <= '0;
                acc_size[k] <= '0;
            end
        end else if (init) begin
            count     <= '0;
            complete  <= 1'b0;
            pend_last <= '0;
        end else begin
            if (in_fire) begin
                acc_data[count] <= word_m;
                acc_size[count] <= size_c;
                if (blk_done) begin
                    count <= '0;
                    if (!out_free) begin
                        complete  <= 1'b1;
                        pend_last <= count;
                    end
                end else begin
                    count <= count + 2'd1;
                end
            end
            if (complete && out_free) begin
                complete <= 1'b0;
            end
        end
    end

    // Output stage: holds its contents until accepted or replaced.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            m_din          <= '0;
            m_din_size     <= '0;
            m_enable_round <= '0;
            m_din_valid    <= 1'b0;
        end else if (init) begin
            m_din          <= '0;
            m_din_size     <= '0;
            m_enable_round <= '0;
            m_din_valid    <= 1'b0;
        end else if (load_out) begin
            m_din          <= blk_data;
            m_din_size     <= blk_size;
            m_enable_round <= blk_last;
            m_din_valid    <= 1'b1;
        end else if (m_din_ready) begin
            m_din_valid    <= 1'b0;
        end
    end

    assign busy = (count != 2'd0) || complete || m_din_valid;

endmodule
